// File: rtl/iiitb_ptvm_change_dispenser.sv
// Change dispenser for the ticket vending machine: charges one ticket from the
// accumulated credit and returns the balance one coin per coin-mechanism handshake.
module iiitb_ptvm_change_dispenser #(
  parameter int CREDIT_W   = 5,
  parameter int PRICE      = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                coin_ack,
  output logic [1:0]          coin_out,
  output logic                ticket,
  output logic                err,
  output logic                busy,
  output logic                done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CREDIT_W-1:0] PRICE_U = CREDIT_W'(PRICE);

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_FIVE = 2'b01;
  localparam logic [1:0] COIN_TEN  = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHARGE  = 3'd1,
    PRESENT = 3'd2,
    GAP     = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [CREDIT_W-1:0] remainder, rem_n, rem_left;
  logic [GAP_W-1:0]    gap_cnt, gap_n;
  logic [1:0]          coin_n;
  logic                ticket_n, err_n, busy_n, done_n;

  // Tens first while two or more units remain, so at most one five and always last.
  function automatic logic [1:0] coin_for(input logic [CREDIT_W-1:0] rem);
    return (rem >= CREDIT_W'(2)) ? COIN_TEN : COIN_FIVE;
  endfunction

  function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] coin);
    return (coin == COIN_TEN) ? CREDIT_W'(2) : CREDIT_W'(1);
  endfunction

  always_comb begin
    state_n  = state;
    rem_n    = remainder;
    gap_n    = gap_cnt;
    coin_n   = coin_out;
    busy_n   = busy;
    ticket_n = 1'b0;
    err_n    = 1'b0;
    done_n   = 1'b0;
    rem_left = remainder - coin_units(coin_out);

    case (state)
      IDLE: begin
        // busy stays up through the done cycle and drops on the edge that clears done
        busy_n = 1'b0;
        if (start) begin
          busy_n  = 1'b1;
          rem_n   = credit;
          state_n = CHARGE;
        end
      end

      CHARGE: begin
        if (remainder >= PRICE_U) begin
          ticket_n = 1'b1;
          rem_n    = remainder - PRICE_U;
        end else begin
          err_n = 1'b1;
        end
        state_n = (rem_n != '0) ? PRESENT : FINISH;
      end

      PRESENT: begin
        // A 00 here means the first coin has not been put up yet; acks are ignored until it is.
        if (coin_out == COIN_NONE) begin
          coin_n = coin_for(remainder);
        end else if (coin_ack) begin
          rem_n = rem_left;
          if (rem_left == '0) begin
            coin_n  = COIN_NONE;
            state_n = FINISH;
          end else if (GAP_CYCLES == 0) begin
            coin_n = coin_for(rem_left);
          end else begin
            coin_n  = COIN_NONE;
            gap_n   = GAP_LOAD;
            state_n = GAP;
          end
        end
      end

      GAP: begin
        if (gap_cnt == '0) begin
          coin_n  = coin_for(remainder);
          state_n = PRESENT;
        end else begin
          gap_n = gap_cnt - GAP_W'(1);
        end
      end

      FINISH: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        coin_n  = COIN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remainder <= '0;
      gap_cnt   <= '0;
      coin_out  <= COIN_NONE;
      ticket    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remainder <= rem_n;
      gap_cnt   <= gap_n;
      coin_out  <= coin_n;
      ticket    <= ticket_n;
      err       <= err_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_iiitb_ptvm_change_dispenser.sv
// Self-checking bench for the change dispenser: directed scenarios plus randomized
// transactions on a GAP_CYCLES=1 and a GAP_CYCLES=0 instance, against a change/coin model.
module tb_iiitb_ptvm_change_dispenser;

  localparam int PRICE = 3;
  localparam int MAXC  = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_g1, coin_ack_g1, start_g0, coin_ack_g0;
  logic [4:0] credit_g1, credit_g0;
  logic [1:0] coin_g1, coin_g0;
  logic       ticket_g1, err_g1, busy_g1, done_g1;
  logic       ticket_g0, err_g0, busy_g0, done_g0;

  int checks = 0;
  int errors = 0;
  int sel_r  = 1;

  logic [1:0] o_coin;
  logic       o_ticket, o_err, o_busy, o_done;

  int  obs_coin[MAXC];
  bit  obs_ticket[MAXC], obs_err[MAXC], obs_busy[MAXC], obs_done[MAXC], obs_ack[MAXC];
  int  acked_q[$];
  int  done_cyc, ticket_cnt, err_cnt, done_cnt, last_cyc;
  bit  timed_out;

  always #5 clk = ~clk;

  iiitb_ptvm_change_dispenser #(.CREDIT_W(5), .PRICE(PRICE), .GAP_CYCLES(1)) dut_g1 (
    .clk(clk), .rst(rst), .start(start_g1), .credit(credit_g1), .coin_ack(coin_ack_g1),
    .coin_out(coin_g1), .ticket(ticket_g1), .err(err_g1), .busy(busy_g1), .done(done_g1)
  );

  iiitb_ptvm_change_dispenser #(.CREDIT_W(5), .PRICE(PRICE), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .start(start_g0), .credit(credit_g0), .coin_ack(coin_ack_g0),
    .coin_out(coin_g0), .ticket(ticket_g0), .err(err_g0), .busy(busy_g0), .done(done_g0)
  );

  always_comb begin
    if (sel_r == 1) begin
      o_coin = coin_g1; o_ticket = ticket_g1; o_err = err_g1; o_busy = busy_g1; o_done = done_g1;
    end else begin
      o_coin = coin_g0; o_ticket = ticket_g0; o_err = err_g0; o_busy = busy_g0; o_done = done_g0;
    end
  end

  // Invariants on both instances every cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((coin_g1 === 2'b11) || (coin_g0 === 2'b11) ||
          (ticket_g1 && err_g1) || (ticket_g0 && err_g0)) begin
        errors++;
        $display("FAIL invariant t=%0t: coin_g1=%b coin_g0=%b ticket/err g1=%b%b g0=%b%b (required coin!=11, not both)",
                 $time, coin_g1, coin_g0, ticket_g1, err_g1, ticket_g0, err_g0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int exp_change(input int cr);
    return (cr >= PRICE) ? cr - PRICE : cr;
  endfunction

  task automatic exp_coins(input int cr, output int q[$]);
    int ch;
    ch = exp_change(cr);
    q.delete();
    for (int i = 0; i < ch / 2; i++) q.push_back(2);
    if (ch % 2 == 1) q.push_back(1);
  endtask

  // ---------------- stimulus / observation ----------------
  task automatic set_in(input int sel, input logic st, input logic [4:0] cr, input logic ak);
    if (sel == 1) begin
      start_g1 = st; credit_g1 = cr; coin_ack_g1 = ak;
      start_g0 = 1'b0; credit_g0 = 5'd0; coin_ack_g0 = 1'b0;
    end else begin
      start_g0 = st; credit_g0 = cr; coin_ack_g0 = ak;
      start_g1 = 1'b0; credit_g1 = 5'd0; coin_ack_g1 = 1'b0;
    end
  endtask

  task automatic record(input int c);
    obs_coin[c]   = int'(o_coin);
    obs_ticket[c] = o_ticket;
    obs_err[c]    = o_err;
    obs_busy[c]   = o_busy;
    obs_done[c]   = o_done;
    if (o_ticket) ticket_cnt++;
    if (o_err)    err_cnt++;
    if (o_done)   done_cnt++;
  endtask

  // hold=0: ack tied high; hold>0: ack after the coin has been seen for hold cycles.
  // noise randomly toggles ack while no coin is shown. Credit is set to 31 after start.
  task automatic drive_txn(input int sel, input int cr, input int hold, input bit noise,
                           input int mid_cyc, input int post);
    int cnt;
    logic [1:0] prev;
    bit a, st;
    logic [4:0] cr5;
    sel_r = sel;
    for (int i = 0; i < MAXC; i++) begin
      obs_coin[i] = 0; obs_ticket[i] = 0; obs_err[i] = 0;
      obs_busy[i] = 0; obs_done[i] = 0; obs_ack[i] = 0;
    end
    acked_q.delete();
    done_cyc = -1; ticket_cnt = 0; err_cnt = 0; done_cnt = 0; last_cyc = 0;
    timed_out = 1'b1; cnt = 0;
    cr5 = cr[4:0];
    set_in(sel, 1'b1, cr5, 1'b0);
    @(posedge clk); #1;
    record(0);
    for (int c = 1; c < MAXC; c++) begin
      prev = o_coin;
      if (hold == 0) a = 1'b1;
      else if (prev != 2'b00) begin
        cnt++;
        a = (cnt >= hold);
      end else a = noise ? ($urandom % 2 == 1) : 1'b0;
      st = (c == mid_cyc);
      set_in(sel, st, 5'd31, a);
      @(posedge clk); #1;
      if (a && prev != 2'b00) begin
        acked_q.push_back(int'(prev));
        obs_ack[c] = 1'b1;
        cnt = 0;
      end
      record(c);
      last_cyc = c;
      if (o_done && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c >= done_cyc + post) begin
        timed_out = 1'b0;
        break;
      end
    end
    set_in(sel, 1'b0, 5'd0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    sel_r = 1;
    set_in(1, 1'b0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({coin_g1, ticket_g1, err_g1, busy_g1, done_g1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_g1: outputs=%b required 000000", {coin_g1, ticket_g1, err_g1, busy_g1, done_g1});
    end
    checks++;
    if ({coin_g0, ticket_g0, err_g0, busy_g0, done_g0} !== 6'b0) begin
      errors++;
      $display("FAIL reset_g0: outputs=%b required 000000", {coin_g0, ticket_g0, err_g0, busy_g0, done_g0});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exact_price;
    int nz;
    drive_txn(1, 3, 0, 1'b0, -1, 2);
    checks++;
    if (timed_out !== 1'b0) begin
      errors++;
      $display("FAIL exact_timeout: done never seen, required done at 2");
      return;
    end
    checks++;
    if (obs_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL exact_busy_start: busy=%b required 1", obs_busy[0]);
    end
    checks++;
    if (obs_ticket[1] !== 1'b1 || ticket_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL exact_ticket: ticket@1=%b tickets=%0d errs=%0d required 1,1,0", obs_ticket[1], ticket_cnt, err_cnt);
    end
    nz = 0;
    for (int c = 0; c <= last_cyc; c++) if (obs_coin[c] != 0) nz++;
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL exact_no_coin: coin cycles=%0d required 0", nz);
    end
    checks++;
    if (done_cyc != 2 || obs_busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL exact_done: done_cyc=%0d busy_after=%b required 2,0", done_cyc, obs_busy[3]);
    end
  endtask

  // Ack tied high: coin i shows at 2 + i*(1+gap), done two cycles after the last coin appears.
  task automatic test_tied(input int sel, input int cr);
    int q[$];
    int exp_tr[MAXC];
    int g, n, done_exp, bad, sum;
    exp_coins(cr, q);
    g = (sel == 1) ? 1 : 0;
    n = q.size();
    for (int c = 0; c < MAXC; c++) exp_tr[c] = 0;
    for (int i = 0; i < n; i++) exp_tr[2 + i * (1 + g)] = q[i];
    done_exp = (n == 0) ? 2 : 2 + (n - 1) * (1 + g) + 2;
    drive_txn(sel, cr, 0, 1'b0, -1, 1);
    checks++;
    if (timed_out !== 1'b0) begin
      errors++;
      $display("FAIL tied_timeout sel=%0d credit=%0d: no done, required done at %0d", sel, cr, done_exp);
      return;
    end
    checks++;
    if (obs_ticket[1] !== (cr >= PRICE) || obs_err[1] !== (cr < PRICE)) begin
      errors++;
      $display("FAIL tied_pulse sel=%0d credit=%0d: ticket=%b err=%b", sel, cr, obs_ticket[1], obs_err[1]);
    end
    bad = 0;
    for (int c = 0; c <= done_exp; c++) if (obs_coin[c] != exp_tr[c]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tied_trace sel=%0d credit=%0d: %0d cycles differ, c2..c5=%0d%0d%0d%0d required %0d%0d%0d%0d",
               sel, cr, bad, obs_coin[2], obs_coin[3], obs_coin[4], obs_coin[5],
               exp_tr[2], exp_tr[3], exp_tr[4], exp_tr[5]);
    end
    sum = 0;
    foreach (acked_q[i]) sum += (acked_q[i] == 2) ? 10 : 5;
    checks++;
    if (done_cyc != done_exp || sum != exp_change(cr) * 5) begin
      errors++;
      $display("FAIL tied_done sel=%0d credit=%0d: done=%0d sum=%0d required %0d,%0d",
               sel, cr, done_cyc, sum, done_exp, exp_change(cr) * 5);
    end
  endtask

  task automatic test_refund;
    drive_txn(1, 2, 3, 1'b1, -1, 1);
    checks++;
    if (timed_out !== 1'b0) begin
      errors++;
      $display("FAIL refund_timeout: no done");
      return;
    end
    checks++;
    if (obs_err[1] !== 1'b1 || err_cnt != 1 || ticket_cnt != 0) begin
      errors++;
      $display("FAIL refund_err: err@1=%b errs=%0d tickets=%0d required 1,1,0", obs_err[1], err_cnt, ticket_cnt);
    end
    checks++;
    if (obs_coin[2] != 2 || obs_coin[3] != 2 || obs_coin[4] != 2 || obs_coin[5] != 0) begin
      errors++;
      $display("FAIL refund_hold: c2..c5=%0d%0d%0d%0d required 2220", obs_coin[2], obs_coin[3], obs_coin[4], obs_coin[5]);
    end
    checks++;
    if (acked_q.size() != 1 || done_cyc != 6) begin
      errors++;
      $display("FAIL refund_done: coins=%0d done=%0d required 1,6", acked_q.size(), done_cyc);
    end
  endtask

  task automatic test_hold_ignore_start;
    int bad;
    drive_txn(1, 7, 5, 1'b0, 4, 3);
    checks++;
    if (timed_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_timeout: no done");
      return;
    end
    bad = 0;
    for (int c = 2; c <= 6; c++) if (obs_coin[c] != 2) bad++;
    checks++;
    if (bad != 0 || obs_coin[7] != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d of c2..c6 not 10, c7=%0d required 0,0", bad, obs_coin[7]);
    end
    checks++;
    if (acked_q.size() != 2 || acked_q[0] != 2 || acked_q[1] != 2) begin
      errors++;
      $display("FAIL hold_coins: count=%0d required two tens", acked_q.size());
    end
    checks++;
    if (ticket_cnt != 1 || done_cnt != 1 || done_cyc != 14) begin
      errors++;
      $display("FAIL hold_start_ignored: tickets=%0d dones=%0d done=%0d required 1,1,14", ticket_cnt, done_cnt, done_cyc);
    end
    checks++;
    if (obs_busy[done_cyc + 1] !== 1'b0 || obs_busy[done_cyc + 3] !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle_after: busy=%b%b required 00", obs_busy[done_cyc + 1], obs_busy[done_cyc + 3]);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    sel_r = 1;
    set_in(1, 1'b1, 5'd10, 1'b1);
    @(posedge clk); #1;
    set_in(1, 1'b0, 5'd31, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (coin_g1 !== 2'b00) begin
      errors++;
      $display("FAIL rmid_first_ack: coin=%b required 00", coin_g1);
    end
    @(posedge clk); #1;
    checks++;
    if (coin_g1 !== 2'b10) begin
      errors++;
      $display("FAIL rmid_second_coin: coin=%b required 10", coin_g1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({coin_g1, ticket_g1, err_g1, busy_g1, done_g1} !== 6'b0) begin
      errors++;
      $display("FAIL rmid_async: outputs=%b required 000000", {coin_g1, ticket_g1, err_g1, busy_g1, done_g1});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (coin_g1 !== 2'b00 || busy_g1 !== 1'b0 || done_g1 !== 1'b0) bad++;
    end
    set_in(1, 1'b0, 5'd0, 1'b0);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rmid_no_resume: %0d cycles active after reset, required 0", bad);
    end
    drive_txn(1, 3, 0, 1'b0, -1, 1);
    checks++;
    if (timed_out !== 1'b0 || obs_ticket[1] !== 1'b1 || done_cyc != 2 || acked_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_restart: timeout=%b ticket=%b done=%0d coins=%0d required 0,1,2,0",
               timed_out, obs_ticket[1], done_cyc, acked_q.size());
    end
  endtask

  task automatic test_zero_credit(input int sel);
    drive_txn(sel, 0, 2, 1'b1, -1, 1);
    checks++;
    if (timed_out !== 1'b0 || obs_err[1] !== 1'b1 || ticket_cnt != 0 || done_cyc != 2 || acked_q.size() != 0) begin
      errors++;
      $display("FAIL zero_credit sel=%0d: timeout=%b err=%b tickets=%0d done=%0d coins=%0d required 0,1,0,2,0",
               sel, timed_out, obs_err[1], ticket_cnt, done_cyc, acked_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] tk, dn, bz;
    sel_r = 1;
    tk = '0; dn = '0; bz = '0;
    set_in(1, 1'b1, 5'd3, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 3) set_in(1, 1'b0, 5'd0, 1'b0);
      tk[c] = ticket_g1;
      dn[c] = done_g1;
      bz[c] = busy_g1;
    end
    checks++;
    if (tk !== 8'b0001_0010 || dn !== 8'b0010_0100) begin
      errors++;
      $display("FAIL b2b_pulses: ticket=%b done=%b required 00010010 00100100", tk, dn);
    end
    checks++;
    if (bz !== 8'b0011_1111) begin
      errors++;
      $display("FAIL b2b_busy: busy=%b required 00111111", bz);
    end
  endtask

  task automatic test_random(input int n);
    int q[$];
    int sel, cr, hold, diff, unstable, late, sum;
    bit noise;
    for (int t = 0; t < n; t++) begin
      sel   = $urandom % 2;
      cr    = $urandom % 32;
      hold  = $urandom_range(0, 4);
      noise = ($urandom % 2 == 1);
      exp_coins(cr, q);
      drive_txn(sel, cr, hold, noise, -1, 2);
      checks++;
      if (timed_out !== 1'b0) begin
        errors++;
        $display("FAIL rnd_timeout t=%0d sel=%0d credit=%0d hold=%0d: no done", t, sel, cr, hold);
        continue;
      end
      checks++;
      if (obs_ticket[1] !== (cr >= PRICE) || obs_err[1] !== (cr < PRICE) ||
          ticket_cnt != int'(cr >= PRICE) || err_cnt != int'(cr < PRICE)) begin
        errors++;
        $display("FAIL rnd_pulse t=%0d credit=%0d: ticket@1=%b err@1=%b tickets=%0d errs=%0d",
                 t, cr, obs_ticket[1], obs_err[1], ticket_cnt, err_cnt);
      end
      diff = (acked_q.size() == q.size()) ? 0 : 1;
      if (diff == 0) foreach (q[i]) if (acked_q[i] != q[i]) diff++;
      sum = 0;
      foreach (acked_q[i]) sum += (acked_q[i] == 2) ? 10 : 5;
      checks++;
      if (diff != 0 || sum != exp_change(cr) * 5) begin
        errors++;
        $display("FAIL rnd_coins t=%0d sel=%0d credit=%0d: count=%0d sum=%0d required count=%0d sum=%0d",
                 t, sel, cr, acked_q.size(), sum, q.size(), exp_change(cr) * 5);
      end
      unstable = 0;
      for (int c = 1; c <= last_cyc; c++)
        if (obs_coin[c - 1] != 0 && !obs_ack[c] && obs_coin[c] != obs_coin[c - 1]) unstable++;
      late = 0;
      for (int c = done_cyc; c <= last_cyc; c++) if (obs_coin[c] != 0) late++;
      checks++;
      if (unstable != 0 || obs_coin[0] != 0 || obs_coin[1] != 0 || late != 0) begin
        errors++;
        $display("FAIL rnd_coin_timing t=%0d credit=%0d: unstable=%0d c0=%0d c1=%0d after_done=%0d required 0",
                 t, cr, unstable, obs_coin[0], obs_coin[1], late);
      end
      checks++;
      if (obs_busy[done_cyc] !== 1'b1 || obs_busy[done_cyc + 1] !== 1'b0 || done_cnt != 1) begin
        errors++;
        $display("FAIL rnd_busy t=%0d: busy@done=%b busy@done+1=%b dones=%0d required 1,0,1",
                 t, obs_busy[done_cyc], obs_busy[done_cyc + 1], done_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_tied(1, 6);
    test_refund();
    test_hold_ignore_start();
    test_reset_mid();
    test_zero_credit(1);
    test_zero_credit(0);
    test_tied(0, 8);
    test_tied(1, 31);
    test_tied(0, 31);
    test_tied(1, 4);
    test_back_to_back();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
